cw_sequencer: RTL
=================

CW_SEQUENCER -- requirements
Module: cw_sequencer

Interface
REQ-001 SHALL have parameter CW_WIDTH, default 40: control-word width driven to the datapath.
REQ-002 SHALL have parameter DEPTH, default 16: number of program entries, power of two, at least 2.
REQ-003 SHALL have parameter HOLD_WIDTH, default 4: width of the per-entry hold count.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin playback at entry 0 (sampled in IDLE only).
REQ-007 stop  in  1  abort playback.
REQ-008 loop  in  1  restart at entry 0 after the last entry (CW_SEQ_LOOP_EN only).
REQ-009 wr_en  in  1  program-entry write strobe.
REQ-010 wr_addr  in  log2(DEPTH)  entry index written.
REQ-011 wr_cw  in  CW_WIDTH  control word stored in the entry.
REQ-012 wr_hold  in  HOLD_WIDTH  extra cycles the entry is held.
REQ-013 wr_last  in  1  marks the entry as the final entry.
REQ-014 control_word  out  CW_WIDTH  current control word; all zeros when not in RUN.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 step  out  log2(DEPTH)  index of the entry currently driven.

Function
REQ-018 States SHALL be IDLE, RUN and DONE.
REQ-019 IDLE with start=1 and stop=0 SHALL go to RUN, step=0, and drive entry 0 on the next cycle.
REQ-020 Each entry SHALL drive control_word for exactly wr_hold+1 consecutive cycles; hold=0 gives 1 cycle.
REQ-021 At hold expiry on a non-last entry SHALL advance step by 1 with no gap cycle.
REQ-022 At hold expiry on a last entry, or at step=DEPTH-1, SHALL go to DONE; step never wraps implicitly.
REQ-023 DONE SHALL last one cycle with done=1 and control_word=0, then go to IDLE.
REQ-024 stop=1 in RUN SHALL go to IDLE on the next edge with control_word=0 and no done pulse.
REQ-025 stop SHALL win over a simultaneous start; start in RUN or DONE SHALL be ignored.
REQ-026 wr_en SHALL write the entry in one cycle in IDLE or DONE; writes while busy=1 SHALL be ignored.
REQ-027 Entry reads SHALL be registered so control_word changes only on clock edges.

Reset
REQ-028 reset low SHALL immediately force IDLE, step=0, hold counter=0, control_word=0, busy=0 and done=0.
REQ-029 Reset asserted mid-playback SHALL abandon playback with no done pulse; program memory is not cleared.

Configuration
REQ-030 With CW_SEQ_LOOP_EN defined, loop=1 at last-entry expiry SHALL restart at step=0 with no DONE cycle and no gap.
REQ-031 Without CW_SEQ_LOOP_EN, the loop port SHALL exist but be ignored, and REQ-022 applies unconditionally.

Structure
REQ-032 Package cw_seq_pkg SHALL hold the state enum and the entry-record field layout (cw, hold, last).
REQ-033 Program storage SHALL be sub-module cw_seq_mem: DEPTH entries, one write port, one registered read port.

Verification
REQ-034 Load entries 0..2 with cw=0x18, 0x9, 0x24, hold=0, last on entry 2; pulse start -> 0x18, 0x9, 0x24 on three consecutive cycles, then one done cycle with cw=0, then IDLE.
REQ-035 Entry 0 with hold=3 and last=1 -> cw held 4 cycles, busy high for 4 cycles, single done pulse.
REQ-036 stop during the second cycle of entry 1 -> cw=0 next cycle, busy=0, done never asserted.
REQ-037 wr_en to entry 1 during RUN -> stored value unchanged on the next playback.
REQ-038 Reset low during RUN -> outputs zero without waiting for a clock edge; a replay after release gives the identical sequence.
REQ-039 CW_SEQ_LOOP_EN with loop=1 and a 2-entry program -> sequence A,B,A,B repeats until stop, with no done pulse.

Source files
------------

// File: rtl/cw_seq_pkg.sv
// Shared types for the control-word sequencer: FSM states and program-entry field layout.
// An entry is packed as {cw, hold, last} with last in bit 0.
package cw_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ENT_LAST_LSB = 0;
  localparam int ENT_HOLD_LSB = 1;

  function automatic int ent_cw_lsb(input int hold_w);
    return ENT_HOLD_LSB + hold_w;
  endfunction

  function automatic int ent_width(input int cw_w, input int hold_w);
    return cw_w + hold_w + 1;
  endfunction

endpackage

// File: rtl/cw_seq_mem.sv
// Program storage: DEPTH entries, one write port, one registered read port.
// Array contents are deliberately not reset so a program survives a reset.
module cw_seq_mem #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_dat,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_dat <= '0;
    end else begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/cw_sequencer.sv
// Plays a programmed list of control words, each held for hold+1 cycles, then pulses done.
// Optional feature macro CW_SEQ_LOOP_EN: i_loop restarts playback at entry 0 instead of finishing.
module cw_sequencer
  import cw_seq_pkg::*;
#(
  parameter int CW_WIDTH   = 40,
  parameter int DEPTH      = 16,
  parameter int HOLD_WIDTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [CW_WIDTH-1:0]      i_wr_cw,
  input  logic [HOLD_WIDTH-1:0]    i_wr_hold,
  input  logic                     i_wr_last,
  output logic [CW_WIDTH-1:0]      o_control_word,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(DEPTH)-1:0] o_step
);

  localparam int AW     = $clog2(DEPTH);
  localparam int EW     = ent_width(CW_WIDTH, HOLD_WIDTH);
  localparam int CW_LSB = ent_cw_lsb(HOLD_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_step;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [AW-1:0]         w_rd_addr;
  logic [HOLD_WIDTH-1:0] w_cnt_nxt;
  logic [EW-1:0]         w_wr_dat;
  logic [EW-1:0]         w_rd_dat;
  logic                  w_expire;
  logic                  w_end;
  logic                  w_wrap;

  assign w_wr_dat[ENT_LAST_LSB]              = i_wr_last;
  assign w_wr_dat[ENT_HOLD_LSB +: HOLD_WIDTH] = i_wr_hold;
  assign w_wr_dat[CW_LSB +: CW_WIDTH]         = i_wr_cw;

  cw_seq_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_wr_en   (i_wr_en && (r_state != ST_RUN)),
    .i_wr_addr (i_wr_addr),
    .i_wr_dat  (w_wr_dat),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  assign w_expire = (r_hold_cnt == w_rd_dat[ENT_HOLD_LSB +: HOLD_WIDTH]);
  assign w_end    = w_rd_dat[ENT_LAST_LSB] || (r_step == AW'(DEPTH - 1));

`ifdef CW_SEQ_LOOP_EN
  assign w_wrap = i_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
  assign w_wrap        = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start && !i_stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire && w_end && !w_wrap) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_control_word = '0;
    case (r_state)
      ST_RUN: begin
        o_busy         = 1'b1;
        o_control_word = w_rd_dat[CW_LSB +: CW_WIDTH];
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // The read address is the entry driven next cycle; it doubles as the next step value.
  always_comb begin
    w_rd_addr = '0;
    w_cnt_nxt = '0;
    if (r_state == ST_RUN && !i_stop) begin
      if (!w_expire) begin
        w_rd_addr = r_step;
        w_cnt_nxt = r_hold_cnt + HOLD_WIDTH'(1);
      end else if (!w_end) begin
        w_rd_addr = r_step + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_step     <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_step     <= w_rd_addr;
      r_hold_cnt <= w_cnt_nxt;
    end
  end

  assign o_step = r_step;

endmodule
